// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector: shift window over accepted bits, Mealy and
// registered match outputs, run-time overlap select and a saturating match counter.
module seq_detect_param #(
   parameter int unsigned                PATTERN_W = 4,
   parameter logic [PATTERN_W-1:0]       PATTERN   = 4'b1001,
   parameter int unsigned                CNT_W     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             din,
   input  logic             din_valid,
   input  logic             overlap,
   input  logic             cnt_clr,
   output logic             dout,
   output logic             dout_q,
   output logic [CNT_W-1:0] match_count
);

   localparam int unsigned          FILL_W   = $clog2(PATTERN_W);
   localparam logic [FILL_W-1:0]    FILL_MAX = FILL_W'(PATTERN_W - 1);

   logic [PATTERN_W-2:0] hist;
   logic [FILL_W-1:0]    fill;
   logic [PATTERN_W-1:0] window;
   logic                 match;

   assign window = {hist, din};
   assign match  = din_valid && (fill == FILL_MAX) && (window == PATTERN);
   assign dout   = match;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hist        <= '0;
         fill        <= '0;
         dout_q      <= 1'b0;
         match_count <= '0;
      end else begin
         dout_q <= match;
         if (din_valid) begin
            hist <= window[PATTERN_W-2:0];
            // Non-overlap restarts the fill so no bit of the matched window is reused.
            if (match && !overlap)
               fill <= '0;
            else if (fill != FILL_MAX)
               fill <= fill + 1'b1;
         end
         if (cnt_clr)
            match_count <= '0;
         else if (match && (match_count != '1))
            match_count <= match_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: three parameterisations share one stimulus bus;
// each step queues the expected outputs of the selected instance for the monitor.
module tb_seq_detect_param;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic din = 1'b0;
   logic din_valid = 1'b0;
   logic overlap = 1'b0;
   logic cnt_clr = 1'b0;

   logic       a_dout, a_q;
   logic [7:0] a_cnt;
   logic       b_dout, b_q;
   logic [1:0] b_cnt;
   logic       c_dout, c_q;
   logic [7:0] c_cnt;

   always #5 clk = ~clk;

   seq_detect_param dut_a (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .overlap(overlap),
      .cnt_clr(cnt_clr), .dout(a_dout), .dout_q(a_q), .match_count(a_cnt)
   );

   seq_detect_param #(.PATTERN_W(4), .PATTERN(4'b1001), .CNT_W(2)) dut_b (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .overlap(overlap),
      .cnt_clr(cnt_clr), .dout(b_dout), .dout_q(b_q), .match_count(b_cnt)
   );

   seq_detect_param #(.PATTERN_W(3), .PATTERN(3'b111), .CNT_W(8)) dut_c (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .overlap(overlap),
      .cnt_clr(cnt_clr), .dout(c_dout), .dout_q(c_q), .match_count(c_cnt)
   );

   typedef struct {
      int          sel;
      string       tag;
      logic        d;
      logic        q;
      int unsigned cnt;
   } exp_t;

   exp_t sbq[$];
   int tests = 0;
   int fails = 0;

   // expected-state tracking for the selected instance
   logic        prev_d = 1'b0;
   int unsigned cnt    = 0;

   function automatic int unsigned cap_of(input int sel);
      return (sel == 1) ? 3 : 255;
   endfunction

   always @(negedge clk) begin
      while (sbq.size() > 0) begin
         exp_t        e;
         logic        ad, aq;
         int unsigned ac;
         e = sbq.pop_front();
         case (e.sel)
            0:       begin ad = a_dout; aq = a_q; ac = int'(a_cnt); end
            1:       begin ad = b_dout; aq = b_q; ac = int'(b_cnt); end
            default: begin ad = c_dout; aq = c_q; ac = int'(c_cnt); end
         endcase
         tests++;
         if (ad !== e.d) begin
            fails++;
            $display("FAIL %s dut%0d dout: got %b expected %b", e.tag, e.sel, ad, e.d);
         end
         tests++;
         if (aq !== e.q) begin
            fails++;
            $display("FAIL %s dut%0d dout_q: got %b expected %b", e.tag, e.sel, aq, e.q);
         end
         tests++;
         if (ac != e.cnt) begin
            fails++;
            $display("FAIL %s dut%0d match_count: got %0d expected %0d", e.tag, e.sel, ac, e.cnt);
         end
      end
   end

   // one clock of stimulus; exp_d is the hand-computed Mealy output for this bit
   task automatic step(input int sel, input string tag, input logic d, input logic v,
                       input logic ovl, input logic clr, input logic exp_d);
      exp_t e;
      @(posedge clk);
      #1;
      reset     = 1'b1;
      din       = d;
      din_valid = v;
      overlap   = ovl;
      cnt_clr   = clr;
      e.sel = sel; e.tag = tag; e.d = exp_d; e.q = prev_d; e.cnt = cnt;
      sbq.push_back(e);
      prev_d = exp_d;
      if (clr)
         cnt = 0;
      else if (exp_d && cnt < cap_of(sel))
         cnt++;
   endtask

   // asynchronous reset asserted mid-cycle; checked before the next clock edge
   task automatic do_reset(input int sel, input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      reset     = 1'b0;
      din       = 1'b1;
      din_valid = 1'b1;
      cnt_clr   = 1'b0;
      e.sel = sel; e.tag = tag; e.d = 1'b0; e.q = 1'b0; e.cnt = 0;
      sbq.push_back(e);
      prev_d = 1'b0;
      cnt    = 0;
   endtask

   // bits[n-1] is the first bit sent; expd gives the expected dout per bit
   task automatic run(input int sel, input string tag, input int n, input logic [31:0] bits,
                      input logic [31:0] expd, input logic ovl);
      for (int i = n - 1; i >= 0; i--)
         step(sel, tag, bits[i], 1'b1, ovl, 1'b0, expd[i]);
   endtask

   initial begin
      exp_t e;
      #2;
      for (int s = 0; s < 3; s++) begin
         e.sel = s; e.tag = "reset_state"; e.d = 1'b0; e.q = 1'b0; e.cnt = 0;
         sbq.push_back(e);
      end

      // overlapping detection of 1001
      run(0, "ovl_stream", 12, 32'b001001001001, 32'b000001001001, 1'b1);
      step(0, "ovl_tail", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

      // non-overlapping: middle match suppressed
      do_reset(0, "rst_a");
      run(0, "novl_stream", 12, 32'b001001001001, 32'b000001000001, 1'b0);
      step(0, "novl_tail", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      // valid gaps hold history
      do_reset(0, "rst_b");
      run(0, "gap_pre", 2, 32'b10, 32'b00, 1'b1);
      for (int i = 0; i < 3; i++)
         step(0, "gap_idle", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      run(0, "gap_post", 2, 32'b01, 32'b01, 1'b1);

      // reset mid-pattern, count non-zero beforehand
      run(0, "pre_rst", 3, 32'b100, 32'b000, 1'b1);
      do_reset(0, "rst_mid");
      run(0, "post_rst", 4, 32'b1001, 32'b0001, 1'b1);
      step(0, "post_rst_tail", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

      // 2-bit counter saturation and clear-over-match priority
      do_reset(1, "rst_sat");
      run(1, "sat_stream", 16, 32'b1001001001001001, 32'b0001001001001001, 1'b1);
      run(1, "sat_more", 2, 32'b00, 32'b00, 1'b1);
      step(1, "clr_match", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      step(1, "after_clr", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

      // 3-bit all-ones pattern
      do_reset(2, "rst_ones");
      run(2, "ones_ovl", 5, 32'b11111, 32'b00111, 1'b1);
      do_reset(2, "rst_ones2");
      run(2, "ones_novl", 6, 32'b111111, 32'b001001, 1'b0);
      step(2, "ones_tail", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 10 && sbq.size() > 0; i++)
         @(negedge clk);
      #1;
      if (sbq.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL drain: %0d entries left, expected 0", sbq.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial bit-pattern detector, successor to the fixed 4-bit Mealy detectors in the FSM library. It compares a window of the last PATTERN_W accepted input bits against a compile-time pattern. Overlapping or non-overlapping detection is selected at run time. It provides both a Mealy (same-cycle) and a Moore-style (registered) match output, plus a saturating match counter. It sits directly behind a serial bit source with an optional valid qualifier.

## Interface

Parameters:
- PATTERN_W, 4, pattern length in bits, must be ≥ 2
- PATTERN, 4'b1001, pattern to detect; MSB is the first (oldest) bit received
- CNT_W, 8, match counter width, must be ≥ 1

Ports:
- clk  input  1  rising-edge clock, the only clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- din  input  1  serial data bit
- din_valid  input  1  din is consumed on a rising edge only when this is 1
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping
- cnt_clr  input  1  synchronous clear of match_count
- dout  output  1  Mealy match: combinational, high in the cycle the final pattern bit is presented
- dout_q  output  1  registered match: high for the one cycle after dout was high on a clock edge
- match_count  output  CNT_W  saturating count of detected matches

## Operation

- State:
  - hist[PATTERN_W-2:0] holds the previous accepted bits, with hist[0] the newest.
  - fill holds the number of accepted bits that may contribute to a match. It is $clog2(PATTERN_W) bits wide and saturates at PATTERN_W-1.
- Window: window = {hist, din}.
- Match: match = din_valid & (fill == PATTERN_W-1) & (window == PATTERN). dout = match.
- On each rising edge with din_valid = 1:
  - hist <= window[PATTERN_W-2:0].
  - If match and overlap = 0, fill <= 0, so no bit of the matched window is reused.
  - Otherwise, fill <= min(fill+1, PATTERN_W-1).
- With din_valid = 0: hist and fill hold, and dout = 0.
- The overlap input is sampled at every edge. A change applies from the next accepted bit and never alters the current cycle's dout.
- dout_q <= match on every edge.
- Counter rules, evaluated in this priority order:
  - If cnt_clr = 1, match_count <= 0. Clear wins over a coincident match.
  - Else, if match and match_count < 2^CNT_W-1, match_count increments by 1.
  - Otherwise, match_count holds. The counter saturates and does not wrap.
- The block has no other FSM. The fill count plays the role of the classic "progress" state; in overlap mode, re-alignment comes for free from the shift window, for any PATTERN.

## Timing

- Reset asserted (reset = 0), immediately and independent of clk:
  - hist = 0, fill = 0, dout_q = 0, match_count = 0.
  - dout = 0, because fill = 0 < PATTERN_W-1.
- Reset released: the first edge with reset = 1 and din_valid = 1 accepts bit 1. The earliest possible match is on the PATTERN_W-th accepted bit.
- Latency:
  - dout: 0 cycles from the final pattern bit (combinational from din and din_valid).
  - dout_q: 1 cycle after dout.
  - match_count: updates on the same edge that samples dout = 1.
- Reset mid-pattern discards all partial history. A full PATTERN_W bits must be received again before a match.
- Back-to-back matches in overlap mode: dout may be high on consecutive accepted bits if PATTERN allows it (e.g. all-ones).
- din must be stable around the rising edge. dout can glitch with din and must only be used synchronously.

## Test plan

Defaults unless noted; one bit per cycle with din_valid = 1.

1. Overlap = 1, stream 0,0,1,0,0,1,0,0,1,0,0,1:
   - dout high on bits 6, 9 and 12 only.
   - dout_q high one cycle after each.
   - match_count = 3.
2. Same stream with overlap = 0:
   - dout high on bits 6 and 12 only (bit 9 is suppressed).
   - match_count = 2.
3. Valid gaps, stream 1,0, then din_valid = 0 for 3 cycles with din = 1, then 0,1:
   - dout = 0 during the gap.
   - dout high on the final 1.
   - match_count = 1.
4. Reset mid-operation, 1,0,0 then reset = 0 for one cycle (async, mid-cycle), then 1:
   - All outputs go to 0 immediately and dout stays 0.
   - A subsequent 1,0,0,1 matches on its 4th bit.
5. CNT_W = 2, overlap = 1, stream 1001001001001001 (5 matches):
   - match_count reads 1, 2, 3, 3, 3.
   - Then cnt_clr = 1 coincident with a further match gives match_count = 0 and dout = 1.
6. PATTERN_W = 3, PATTERN = 3'b111, overlap = 1, five 1s:
   - dout high on bits 3, 4 and 5.
   - With overlap = 0, dout is high on bit 3 only; a sixth 1 then gives a match on bit 6.
